pipe_stage_buf: RTL and testbench
=================================

# pipe_stage_buf

Parametrised successor to the fixed-field decode-stage pipeline register: a generic ready/valid pipeline stage with a 2-entry skid buffer, a flush that inserts bubbles, and optional per-stage performance counters. Any IF/ID/EX/MEM boundary of the RISC-V pipeline instantiates it. Stage fields are split into a control vector, zeroed on every bubble, and a data vector. The registered `in_ready` breaks the combinational stall path that runs backwards through the pipeline.

## Interface
Parameters:
- `DATA_W`, 96: width of the data payload (operands, immediates).
- `CTRL_W`, 24: width of the control payload (wr_en, mem_en, mem_wr, opcode, fn_3, fn_7, rd_sel ...).
- `CNT_W`, 16: width of each performance counter.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `in_valid`  in  1: upstream presents an instruction.
- `in_ready`  out  1: stage can accept an instruction. Registered.
- `in_ctrl`  in  CTRL_W: upstream control fields.
- `in_data`  in  DATA_W: upstream data fields.
- `flush`  in  1: discard all held instructions (branch or exception).
- `out_valid`  out  1: stage presents an instruction downstream.
- `out_ready`  in  1: downstream accepts.
- `out_ctrl`  out  CTRL_W: control to next stage. All zero whenever `out_valid`=0.
- `out_data`  out  DATA_W: data to next stage.
- `clr_cnt`  in  1: synchronous clear of the counters.
- `stall_cnt`  out  CNT_W: cycles with `out_valid`=1 and `out_ready`=0.
- `bubble_cnt`  out  CNT_W: cycles with `out_valid`=0.

## Operation
- Handshake signals:
  - in_fire = `in_valid` & `in_ready`.
  - out_fire = `out_valid` & `out_ready`.
- Storage: a main register feeding the outputs, plus a skid register. Each holds ctrl and data.
- States and transitions:
  - EMPTY (`out_valid`=0, `in_ready`=1):
    - in_fire → FULL, main ← in.
  - FULL (`out_valid`=1, `in_ready`=1):
    - in_fire & out_fire → FULL, main ← in.
    - in_fire & !out_fire → SKID, skid ← in.
    - !in_fire & out_fire → EMPTY.
    - Otherwise hold.
  - SKID (`out_valid`=1, `in_ready`=0):
    - out_fire → FULL, main ← skid.
    - Otherwise hold. Skid contents never overwrite main while out_fire=0.
- `flush`:
  - Forces EMPTY from any state on the next edge.
  - Has priority over every simultaneous in_fire and out_fire. An input accepted in the flush cycle is dropped.
  - Data registers may keep stale values. `out_ctrl` reads zero because `out_valid`=0.
- Bubble rule: `out_ctrl` = main_ctrl & {CTRL_W{`out_valid`}}. `out_data` is not masked.
- Ordering: instructions leave strictly in acceptance order. None is lost or duplicated except when dropped by flush.
- Upstream may deassert `in_valid` freely. The stage does not require `in_valid` to stay asserted.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - State = EMPTY, so `out_valid`=0, `in_ready`=1.
  - Main and skid ctrl = 0, data = 0.
  - `stall_cnt`=0, `bubble_cnt`=0.
- Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- Latency: 1 cycle. An instruction accepted at edge N is presented with `out_valid`=1 after edge N.
- Throughput: 1 instruction per cycle when `out_ready` is held at 1.
- `in_ready` is a flop output. It has no combinational dependence on `out_ready`, `in_valid` or `flush`.
- `out_valid`, `out_ctrl` and `out_data` come from flops plus the AND mask. There is no combinational path from `in_*` to `out_*`.
- Flush asserted at edge N: `out_valid`=0 and `in_ready`=1 after edge N. A new instruction can be accepted at edge N+1.

## Configuration
- `PIPE_STAGE_PERF_EN` defined:
  - `stall_cnt` and `bubble_cnt` increment once per qualifying cycle.
  - They saturate at 2^CNT_W−1 and do not wrap.
  - `clr_cnt` zeroes both on the next edge and has priority over increment.
  - Counters are not affected by `flush`.
- `PIPE_STAGE_PERF_EN` undefined:
  - No counter flops are built.
  - `stall_cnt` and `bubble_cnt` are tied to 0 and `clr_cnt` is ignored.
  - Ports remain, so instantiations do not change.

## Test plan
- Reset then streaming: deassert `rst_n` for 3 cycles, then drive in_ctrl=0x000001..0x000005 on consecutive cycles with `out_ready`=1 → out_ctrl shows 0x000001..0x000005 in order, each one cycle after acceptance; `in_ready` stays 1.
- Skid fill: accept ctrl 0xA, then ctrl 0xB with `out_ready`=0 → state SKID and `in_ready`=0; out_ctrl holds 0xA. Raise `out_ready` → 0xA, then 0xB, each for one cycle; `in_ready` returns to 1 one cycle after the first out_fire.
- Flush priority: in SKID holding 0xA/0xB, assert `flush` together with `in_valid` carrying 0xC and `out_ready`=1 → next cycle out_valid=0 and out_ctrl=0; 0xB and 0xC never appear; `in_ready`=1.
- Async reset mid-stream: pull `rst_n` low between clock edges while in FULL → `out_valid` and `out_ctrl` go to 0 before the next edge.
- Counters (with macro): CNT_W=4, hold `out_valid`=1 and `out_ready`=0 for 20 cycles → stall_cnt saturates at 15. Pulse `clr_cnt` → 0 next cycle. Without macro → both counters read 0 throughout.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Ready/valid pipeline stage with a 2-entry skid buffer, bubble-inserting flush
// and optional stall/bubble counters (enabled by defining PIPE_STAGE_PERF_EN).
module pipe_stage_buf #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 24,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t state;
    entry_t main_q, skid_q, in_ent;
    logic   out_valid_q, in_ready_q;
    logic   in_fire, out_fire;

    assign in_ent   = '{ctrl: in_ctrl, data: in_data};
    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    // Handshake flags are kept as their own flops so neither port sees
    // combinational logic from the state decode or from the other side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (flush) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_q      <= in_ent;
                        state       <= FULL;
                        out_valid_q <= 1'b1;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_ent;
                    end else if (in_fire) begin
                        skid_q     <= in_ent;
                        state      <= SKID;
                        in_ready_q <= 1'b0;
                    end else if (out_fire) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                SKID: begin
                    if (out_fire) begin
                        main_q     <= skid_q;
                        state      <= FULL;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_ctrl  = main_q.ctrl & {CTRL_W{out_valid_q}};
    assign out_data  = main_q.data;

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_q, bubble_q;

    // Saturating counters; clear wins over increment, flush does not touch them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else if (clr_cnt) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (out_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}}))
                stall_q <= stall_q + 1'b1;
            if (!out_valid_q && (bubble_q != {CNT_W{1'b1}}))
                bubble_q <= bubble_q + 1'b1;
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    logic clr_unused;
    assign clr_unused = clr_cnt;
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: streaming, skid fill/drain, flush priority,
// async reset mid-stream and the performance counters (either build).
module tb_pipe_stage_buf;
    localparam int DATA_W = 96;
    localparam int CTRL_W = 24;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid, out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic              clr_cnt;
    logic [CNT_W-1:0]  stall_cnt, bubble_cnt;

    int tests = 0;
    int fails = 0;

    pipe_stage_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .clr_cnt(clr_cnt), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] dat(input logic [CTRL_W-1:0] c);
        return {c, ~c, 48'h5A5A_0000_0000 ^ {24'h0, c}};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic rdy);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = dat(c);
        out_ready = rdy;
    endtask

    initial begin
        logic [CNT_W-1:0] exp_sat, exp_one;
`ifdef PIPE_STAGE_PERF_EN
        exp_sat = 4'd15;
        exp_one = 4'd1;
`else
        exp_sat = 4'd0;
        exp_one = 4'd0;
`endif
        rst_n = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
        drive(1'b0, 24'h0, 1'b0);
        repeat (3) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_bubble", bubble_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // streaming at full rate
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 24'(i), 1'b1);
            tick();
            chk("stream_valid", out_valid, 1);
            chk("stream_ctrl", out_ctrl, 128'(i));
            chk("stream_data", out_data, dat(24'(i)));
            chk("stream_ready", in_ready, 1);
        end
        drive(1'b0, 24'h0, 1'b1);
        tick();
        chk("drain_valid", out_valid, 0);
        chk("drain_ctrl_masked", out_ctrl, 0);

        // skid fill and drain
        drive(1'b1, 24'hA, 1'b0); tick();
        chk("skid_a_ctrl", out_ctrl, 24'hA);
        chk("skid_a_ready", in_ready, 1);
        drive(1'b1, 24'hB, 1'b0); tick();
        chk("skid_full_ready", in_ready, 0);
        chk("skid_full_ctrl", out_ctrl, 24'hA);
        drive(1'b0, 24'h0, 1'b0); tick();
        chk("skid_hold_ctrl", out_ctrl, 24'hA);
        chk("skid_hold_data", out_data, dat(24'hA));
        chk("skid_hold_ready", in_ready, 0);
        drive(1'b0, 24'h0, 1'b1); tick();
        chk("skid_drain_b", out_ctrl, 24'hB);
        chk("skid_drain_b_data", out_data, dat(24'hB));
        chk("skid_drain_ready", in_ready, 1);
        tick();
        chk("skid_empty", out_valid, 0);

        // flush from SKID while presenting a new input
        drive(1'b1, 24'hA, 1'b0); tick();
        drive(1'b1, 24'hB, 1'b0); tick();
        chk("fl_pre_ready", in_ready, 0);
        drive(1'b1, 24'hC, 1'b1); flush = 1'b1; tick();
        flush = 1'b0;
        chk("fl_valid", out_valid, 0);
        chk("fl_ctrl", out_ctrl, 0);
        chk("fl_ready", in_ready, 1);
        drive(1'b0, 24'h0, 1'b1); tick();
        chk("fl_no_leak", out_valid, 0);
        drive(1'b1, 24'hD, 1'b0); tick();
        chk("fl_accept_d", out_ctrl, 24'hD);
        // flush from FULL drops the simultaneous input
        drive(1'b1, 24'hE, 1'b0); flush = 1'b1; tick();
        flush = 1'b0;
        chk("fl_full_valid", out_valid, 0);
        chk("fl_full_ready", in_ready, 1);
        drive(1'b0, 24'h0, 1'b1); tick();
        chk("fl_full_drop_e", out_valid, 0);

        // async reset between edges
        drive(1'b1, 24'hF, 1'b0); tick();
        drive(1'b0, 24'h0, 1'b0);
        chk("ar_pre_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_ctrl", out_ctrl, 0);
        chk("ar_data", out_data, 0);
        chk("ar_ready", in_ready, 1);
        #1 rst_n = 1'b1;

        // counters
        clr_cnt = 1'b1; tick();
        clr_cnt = 1'b0;
        chk("cnt_clr0_stall", stall_cnt, 0);
        chk("cnt_clr0_bubble", bubble_cnt, 0);
        drive(1'b1, 24'h1, 1'b0); tick();
        drive(1'b0, 24'h0, 1'b0);
        repeat (20) tick();
        chk("cnt_stall_sat", stall_cnt, exp_sat);
        chk("cnt_bubble_one", bubble_cnt, exp_one);
        clr_cnt = 1'b1; tick();
        clr_cnt = 1'b0;
        chk("cnt_clr_stall", stall_cnt, 0);
        chk("cnt_clr_bubble", bubble_cnt, 0);
        tick();
        chk("cnt_restart", stall_cnt, exp_one);
        flush = 1'b1; tick();
        flush = 1'b0;
        chk("cnt_flush_keeps", stall_cnt, exp_one + exp_one);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule
